// File: rtl/decoder3x8_framer.sv
// Registered 3-to-8 one-hot decoder with frame accumulation.
// Accepted codes are decoded to one-hot words and OR-accumulated over
// FRAME_LEN codes. Each completed frame is offered on a valid/ready
// handshake, and code_ready stays low until the consumer takes the frame.
// Optional feature: define DECODER3X8_DUP_CHECK_EN to flag frames in which
// a code was repeated. Without it, frame_dup is tied to 0.
module decoder3x8_framer #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [7:0] frame_mask,
  output logic       frame_complete,
  output logic       frame_dup,
  output logic       frame_valid,
  input  logic       frame_ready
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       frame_mask_q, frame_mask_d;
  logic             frame_complete_q, frame_complete_d;
  logic             frame_valid_q, frame_valid_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] onehot;
  logic       accept;

`ifdef DECODER3X8_DUP_CHECK_EN
  logic dup_q, dup_d;
  logic frame_dup_q, frame_dup_d;
  logic hit;
`endif

  assign onehot     = 8'b0000_0001 << code;
  assign code_ready = rst_n && (state_q == COLLECT);
  assign accept     = code_valid && code_ready;

`ifdef DECODER3X8_DUP_CHECK_EN
  assign hit = |(acc_q & onehot);
`endif

  // Next-state logic: decode on accept, accumulate, complete frames and release them on handshake
  always_comb begin
    state_d          = state_q;
    data_d           = data_q;
    data_valid_d     = 1'b0;
    frame_mask_d     = frame_mask_q;
    frame_complete_d = frame_complete_q;
    frame_valid_d    = frame_valid_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
`ifdef DECODER3X8_DUP_CHECK_EN
    dup_d            = dup_q;
    frame_dup_d      = frame_dup_q;
`endif

    if (accept) begin
      data_d       = onehot;
      data_valid_d = 1'b1;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            frame_mask_d     = acc_q | onehot;
            frame_complete_d = ((acc_q | onehot) == 8'hFF);
            frame_valid_d    = 1'b1;
            acc_d            = 8'h00;
            cnt_d            = '0;
            state_d          = HOLD;
`ifdef DECODER3X8_DUP_CHECK_EN
            frame_dup_d      = dup_q | hit;
            dup_d            = 1'b0;
`endif
          end else begin
            acc_d = acc_q | onehot;
            cnt_d = cnt_q + CNT_W'(1);
`ifdef DECODER3X8_DUP_CHECK_EN
            dup_d = dup_q | hit;
`endif
          end
        end
      end
      HOLD: begin
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State register with synchronous active-low reset that discards any partial or pending frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= COLLECT;
      data_q           <= 8'h00;
      data_valid_q     <= 1'b0;
      frame_mask_q     <= 8'h00;
      frame_complete_q <= 1'b0;
      frame_valid_q    <= 1'b0;
      acc_q            <= 8'h00;
      cnt_q            <= '0;
`ifdef DECODER3X8_DUP_CHECK_EN
      dup_q            <= 1'b0;
      frame_dup_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      data_q           <= data_d;
      data_valid_q     <= data_valid_d;
      frame_mask_q     <= frame_mask_d;
      frame_complete_q <= frame_complete_d;
      frame_valid_q    <= frame_valid_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
`ifdef DECODER3X8_DUP_CHECK_EN
      dup_q            <= dup_d;
      frame_dup_q      <= frame_dup_d;
`endif
    end
  end

  assign data           = data_q;
  assign data_valid     = data_valid_q;
  assign frame_mask     = frame_mask_q;
  assign frame_complete = frame_complete_q;
  assign frame_valid    = frame_valid_q;

`ifdef DECODER3X8_DUP_CHECK_EN
  assign frame_dup = frame_dup_q;
`else
  assign frame_dup = 1'b0;
`endif

endmodule

// File: tb/tb_decoder3x8_framer.sv
// Testbench for decoder3x8_framer.
// Two instances run side by side: FRAME_LEN=8 (dut0) and FRAME_LEN=1 (dut1).
// A behavioural model tracks, per instance, how often each code occurred in
// the current frame and whether a completed frame is waiting for its consumer.
// Directed sequences with literal expectations are followed by random traffic.
module tb_decoder3x8_framer;

`ifdef DECODER3X8_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code           [2];
  logic       code_valid     [2];
  logic       code_ready     [2];
  logic [7:0] data           [2];
  logic       data_valid     [2];
  logic [7:0] frame_mask     [2];
  logic       frame_complete [2];
  logic       frame_dup      [2];
  logic       frame_valid    [2];
  logic       frame_ready    [2];

  int errors = 0;
  int checks = 0;

  int fl [2] = '{8, 1};

  int         m_hits [2][8];
  int         m_n    [2];
  bit         m_pend [2];
  logic [7:0] m_data [2];
  logic [7:0] m_mask [2];
  bit         m_dv   [2];
  bit         m_fc   [2];
  bit         m_fd   [2];
  bit         m_fv   [2];

  decoder3x8_framer #(.FRAME_LEN(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .code(code[0]), .code_valid(code_valid[0]),
    .code_ready(code_ready[0]), .data(data[0]), .data_valid(data_valid[0]),
    .frame_mask(frame_mask[0]), .frame_complete(frame_complete[0]),
    .frame_dup(frame_dup[0]), .frame_valid(frame_valid[0]),
    .frame_ready(frame_ready[0])
  );

  decoder3x8_framer #(.FRAME_LEN(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .code(code[1]), .code_valid(code_valid[1]),
    .code_ready(code_ready[1]), .data(data[1]), .data_valid(data_valid[1]),
    .frame_mask(frame_mask[1]), .frame_complete(frame_complete[1]),
    .frame_dup(frame_dup[1]), .frame_valid(frame_valid[1]),
    .frame_ready(frame_ready[1])
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [2:0] c, input logic v);
    @(negedge clk);
    code[k]       = c;
    code_valid[k] = v;
  endtask

  // Reference model advances on each rising edge, then every output of both instances is compared
  always begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int b = 0; b < 8; b++) m_hits[k][b] = 0;
        m_n[k]    = 0;
        m_pend[k] = 1'b0;
        m_data[k] = 8'h00;
        m_mask[k] = 8'h00;
        m_dv[k]   = 1'b0;
        m_fc[k]   = 1'b0;
        m_fd[k]   = 1'b0;
        m_fv[k]   = 1'b0;
      end else begin
        m_dv[k] = 1'b0;
        if (m_pend[k]) begin
          if (frame_ready[k]) begin
            m_pend[k] = 1'b0;
            m_fv[k]   = 1'b0;
          end
        end else if (code_valid[k]) begin
          m_data[k]          = 8'h00;
          m_data[k][code[k]] = 1'b1;
          m_dv[k]            = 1'b1;
          m_hits[k][code[k]]++;
          m_n[k]++;
          if (m_n[k] == fl[k]) begin
            logic [7:0] mask;
            bit         repeated;
            mask     = 8'h00;
            repeated = 1'b0;
            for (int b = 0; b < 8; b++) begin
              if (m_hits[k][b] > 0) mask[b] = 1'b1;
              if (m_hits[k][b] > 1) repeated = 1'b1;
              m_hits[k][b] = 0;
            end
            m_mask[k] = mask;
            m_fc[k]   = (mask == 8'hFF);
            m_fd[k]   = DUP_EN && repeated;
            m_fv[k]   = 1'b1;
            m_pend[k] = 1'b1;
            m_n[k]    = 0;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d.data", k),           data[k],                 m_data[k]);
      checkOutput($sformatf("dut%0d.data_valid", k),     8'(data_valid[k]),       8'(m_dv[k]));
      checkOutput($sformatf("dut%0d.frame_mask", k),     frame_mask[k],           m_mask[k]);
      checkOutput($sformatf("dut%0d.frame_complete", k), 8'(frame_complete[k]),   8'(m_fc[k]));
      checkOutput($sformatf("dut%0d.frame_dup", k),      8'(frame_dup[k]),        8'(m_fd[k]));
      checkOutput($sformatf("dut%0d.frame_valid", k),    8'(frame_valid[k]),      8'(m_fv[k]));
      checkOutput($sformatf("dut%0d.code_ready", k),     8'(code_ready[k]),       8'(rst_n && !m_pend[k]));
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic
  initial begin
    logic [2:0] bp_codes [8];
    logic [2:0] rs_codes [8];
    bp_codes = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd0, 3'd0};
    rs_codes = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      code[k]        = 3'd0;
      code_valid[k]  = 1'b1;
      frame_ready[k] = 1'b1;
    end

    // reset held with code_valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst.code_ready",  8'(code_ready[0]),  8'h00);
      checkOutput("rst.data",        data[0],            8'h00);
      checkOutput("rst.data_valid",  8'(data_valid[0]),  8'h00);
      checkOutput("rst.frame_valid", 8'(frame_valid[0]), 8'h00);
    end
    rst_n         = 1'b1;
    code_valid[0] = 1'b0;
    code_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("rel.code_ready0", 8'(code_ready[0]), 8'h01);
    checkOutput("rel.code_ready1", 8'(code_ready[1]), 8'h01);

    // walking codes 0..7
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 3'(i), 1'b1);
      if (i > 0) begin
        checkOutput("walk.data", data[0], 8'h01 << (i - 1));
        checkOutput("walk.data_valid", 8'(data_valid[0]), 8'h01);
      end
    end
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("walk.last_data",  data[0],                 8'h80);
    checkOutput("walk.frame_valid", 8'(frame_valid[0]),     8'h01);
    checkOutput("walk.frame_mask", frame_mask[0],           8'hFF);
    checkOutput("walk.complete",   8'(frame_complete[0]),   8'h01);
    checkOutput("walk.dup",        8'(frame_dup[0]),        8'h00);
    checkOutput("walk.code_ready", 8'(code_ready[0]),       8'h00);
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("walk.taken_valid", 8'(frame_valid[0]), 8'h00);
    checkOutput("walk.taken_ready", 8'(code_ready[0]),  8'h01);

    // repeated code 3
    for (int i = 0; i < 8; i++) applyStimulus(0, 3'd3, 1'b1);
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("rep.frame_mask", frame_mask[0],         8'h08);
    checkOutput("rep.complete",   8'(frame_complete[0]), 8'h00);
    checkOutput("rep.dup",        8'(frame_dup[0]),      DUP_EN ? 8'h01 : 8'h00);
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("rep.taken_valid", 8'(frame_valid[0]), 8'h00);

    // backpressure: frame held while frame_ready is low
    frame_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(0, bp_codes[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 3'($urandom_range(0, 7)), 1'b1);
      checkOutput("bp.frame_valid", 8'(frame_valid[0]), 8'h01);
      checkOutput("bp.frame_mask",  frame_mask[0],      8'h17);
      checkOutput("bp.code_ready",  8'(code_ready[0]),  8'h00);
      if (i > 0) checkOutput("bp.data_valid", 8'(data_valid[0]), 8'h00);
    end
    applyStimulus(0, 3'd0, 1'b0);
    frame_ready[0] = 1'b1;
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("bp.release_valid", 8'(frame_valid[0]), 8'h00);
    checkOutput("bp.release_ready", 8'(code_ready[0]),  8'h01);

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) applyStimulus(0, 3'(i), 1'b1);
    @(negedge clk);
    rst_n         = 1'b0;
    code_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(0, rs_codes[i], 1'b1);
    applyStimulus(0, 3'd0, 1'b0);
    checkOutput("mrst.frame_mask",  frame_mask[0],         8'hFF);
    checkOutput("mrst.complete",    8'(frame_complete[0]), 8'h01);
    checkOutput("mrst.frame_valid", 8'(frame_valid[0]),    8'h01);
    checkOutput("mrst.dup",         8'(frame_dup[0]),      8'h00);
    applyStimulus(0, 3'd0, 1'b0);

    // single-code frames on the FRAME_LEN=1 instance
    applyStimulus(1, 3'd6, 1'b1);
    checkOutput("fl1.ready_a", 8'(code_ready[1]), 8'h01);
    applyStimulus(1, 3'd2, 1'b1);
    checkOutput("fl1.mask_a",  frame_mask[1],      8'h40);
    checkOutput("fl1.valid_a", 8'(frame_valid[1]), 8'h01);
    checkOutput("fl1.ready_b", 8'(code_ready[1]),  8'h00);
    applyStimulus(1, 3'd2, 1'b1);
    checkOutput("fl1.valid_b", 8'(frame_valid[1]), 8'h00);
    checkOutput("fl1.ready_c", 8'(code_ready[1]),  8'h01);
    applyStimulus(1, 3'd0, 1'b0);
    checkOutput("fl1.mask_b",  frame_mask[1],      8'h04);
    checkOutput("fl1.valid_c", 8'(frame_valid[1]), 8'h01);
    checkOutput("fl1.ready_d", 8'(code_ready[1]),  8'h00);
    applyStimulus(1, 3'd0, 1'b0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        code[k]        = 3'($urandom_range(0, 7));
        code_valid[k]  = ($urandom_range(0, 3) != 0);
        frame_ready[k] = ($urandom_range(0, 2) != 0);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
